aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- On-the-fly AES-128 key schedule. It sits directly downstream of the AES round controller (AesCtrl) and consumes its start pulse and round flags.
- It presents the round key for the current round to the round datapath in the same cycle as that round's flag.
- It captures one 128-bit cipher key per operation and derives keys 1..10 one round at a time. It does not store all 11 keys.

Parameters:
- KEY_W, 128, cipher/round key width (fixed for AES-128)
- NUM_ROUNDS, 10, number of key-expansion steps per operation

Ports:
- iClk  input  1  clock
- iRsn  input  1  reset, synchronous, active-low
- iStAes  input  1  start pulse, same signal that drives the controller
- iKey  input  128  cipher key; sampled only on accepted start
- iInitRoundFlag  input  1  controller init-round flag
- iFstRoundFlag  input  1  controller first-round flag
- iMidRoundFlag  input  1  controller mid-round flag (high 8 consecutive cycles)
- iLstRoundFlag  input  1  controller last-round flag
- oRoundKey  output  128  current round key (registered)
- oRoundIdx  output  4  index of the key on oRoundKey, 0..10
- oKeyBusy  output  1  an operation is in progress
- oKeyErr  output  1  sticky sequencing error

Behaviour:
- Reset values (synchronous, iRsn=0): rKey=0, rRcon=8'h01, oRoundIdx=0, oKeyBusy=0, oKeyErr=0. Reset mid-operation aborts immediately; no partial state is retained.
- Start: iStAes=1 while oKeyBusy=0 gives, at the next edge, rKey<=iKey, rRcon<=8'h01, idx<=0, busy<=1, oKeyErr<=0. iStAes while busy is ignored.
- Step: at an edge where busy=1 and (Init|Fst|Mid flag)=1:
  - rKey<=Next(rKey,rRcon), idx<=idx+1
  - rRcon<=xtime(rRcon) = rRcon[7] ? {rRcon[6:0],0}^8'h1B : {rRcon[6:0],0}
- Next(): words w0=key[127:96] .. w3=key[31:0].
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0=w0^t, n1=n0^w1, n2=n1^w2, n3=n2^w3
- Resulting alignment, zero added latency versus the round flags:
  - Init cycle shows key0
  - Fst shows key1
  - Mid cycles show key2..key9
  - Lst shows key10
- Rcon sequence seen: 01,02,04,08,10,20,40,80,1B,36.
- Finish: the edge with iLstRoundFlag=1 and busy=1 sets busy<=0. rKey and idx hold key10 and 10 until the next start.
- Errors:
  - A step flag when idx==10 sets oKeyErr=1; key and idx saturate.
  - Any round flag while busy=0 sets oKeyErr=1; the flag is otherwise ignored.
  - Lst with idx!=10 sets oKeyErr=1 and still clears busy.
  - Flags are treated as mutually exclusive. If more than one is high in a cycle, oKeyErr=1 and no step occurs.
- Simultaneous start and Lst: Lst is processed first and busy clears; the start is ignored in that cycle.

Optional Feature:
- Macro: AES_KEY_LAST_CACHE_EN.
- Defined:
  - Adds output oLastKey[127:0] and oLastKeyVld[1], both reset to 0.
  - On the Lst edge with idx==10, oLastKey<=rKey (key10) and oLastKeyVld<=1.
  - An accepted start clears oLastKeyVld; oLastKey holds its value. This lets a later decryptor begin from key10.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package/include (aes_pkg):
  - KEY_W=128, NUM_ROUNDS=10
  - RCON_INIT=8'h01, RCON_POLY=8'h1B
  - round-index width 4
  - the 256-entry S-box constant table, shared with the SubBytes datapath
- Sub-module aes_sub_word: combinational 32-bit SubWord, four S-box lookups. Instantiated once in aes_key_expand.

Test Plan:
- FIPS-197 key:
  - Stimulus: iKey=2b7e151628aed2a6abf7158809cf4f3c with start, then a full controller sequence.
  - Response: Init shows key0 = iKey; Fst shows a0fafe1788542cb123a339392a6c7605; Lst shows d014f9a8c9ee2589e13f0cc8b6630ca6 with idx=10.
- All-zero key:
  - Stimulus: iKey=0 with start.
  - Response: Fst oRoundKey=62636363626363636263636362636363; oKeyErr=0 throughout; busy falls after Lst.
- Start while busy:
  - Stimulus: a second iStAes with a different key during Mid.
  - Response: ignored; key10 still matches the first key.
- Reset mid-operation:
  - Stimulus: iRsn=0 for one cycle during Mid.
  - Response: all outputs 0, rRcon=01; a fresh start then produces the correct key1.
- Sequencing errors:
  - An extra Mid flag at idx==10, or a lone Fst flag while idle, gives oKeyErr=1 and key unchanged.
  - The next accepted start clears oKeyErr.
- With AES_KEY_LAST_CACHE_EN:
  - After the FIPS run, oLastKey=d014f9a8c9ee2589e13f0cc8b6630ca6 and oLastKeyVld=1.
  - The next start clears oLastKeyVld.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: widths, Rcon generation and the forward S-box table
// used by both the key schedule and the SubBytes datapath.
package aes_pkg;
    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int IDX_W      = 4;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ RCON_POLY) : {b[6:0], 1'b0};
    endfunction
endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: one S-box lookup per byte lane.
module aes_sub_word
    import aes_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0][7:0] word,
    output logic [NUM_LANES-1:0][7:0] subWord
);
    for (genvar lane = 0; lane < NUM_LANES; lane++) begin : gLane
        assign subWord[lane] = SBOX[word[lane]];
    end
endmodule

// File: rtl/aes_key_expand.sv
// On-the-fly AES-128 key schedule tracking the round controller flags.
// Optional last-key cache (oLastKey/oLastKeyVld) enabled by AES_KEY_LAST_CACHE_EN.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic             iClk,
    input  logic             iRsn,
    input  logic             iStAes,
    input  logic [KEY_W-1:0] iKey,
    input  logic             iInitRoundFlag,
    input  logic             iFstRoundFlag,
    input  logic             iMidRoundFlag,
    input  logic             iLstRoundFlag,
`ifdef AES_KEY_LAST_CACHE_EN
    output logic [KEY_W-1:0] oLastKey,
    output logic             oLastKeyVld,
`endif
    output logic [KEY_W-1:0] oRoundKey,
    output logic [IDX_W-1:0] oRoundIdx,
    output logic             oKeyBusy,
    output logic             oKeyErr
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    logic [KEY_W-1:0] rKey;
    logic [7:0]       rRcon;
    logic [IDX_W-1:0] rIdx;
    logic             rBusy;
    logic             rErr;

    logic [31:0]      w0, w1, w2, w3, subRot, t;
    logic [31:0]      n0, n1, n2, n3;
    logic [KEY_W-1:0] nextKey;
    logic [2:0]       flagCnt;
    logic             stepFlag, anyFlag, multiFlag;

    assign {w0, w1, w2, w3} = rKey;

    aes_sub_word uSubWord (
        .word    ({w3[23:0], w3[31:24]}),
        .subWord (subRot)
    );

    assign t       = subRot ^ {rRcon, 24'h0};
    assign n0      = w0 ^ t;
    assign n1      = n0 ^ w1;
    assign n2      = n1 ^ w2;
    assign n3      = n2 ^ w3;
    assign nextKey = {n0, n1, n2, n3};

    assign flagCnt   = 3'(iInitRoundFlag) + 3'(iFstRoundFlag) + 3'(iMidRoundFlag) + 3'(iLstRoundFlag);
    assign anyFlag   = (flagCnt != 3'd0);
    assign multiFlag = (flagCnt > 3'd1);
    assign stepFlag  = iInitRoundFlag | iFstRoundFlag | iMidRoundFlag;

    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            rKey  <= '0;
            rRcon <= RCON_INIT;
            rIdx  <= '0;
            rBusy <= 1'b0;
            rErr  <= 1'b0;
        end else if (!rBusy) begin
            if (iStAes) begin
                rKey  <= iKey;
                rRcon <= RCON_INIT;
                rIdx  <= '0;
                rBusy <= 1'b1;
                rErr  <= 1'b0;
            end else if (anyFlag) begin
                rErr <= 1'b1;
            end
        end else if (multiFlag) begin
            rErr <= 1'b1;
        end else if (iLstRoundFlag) begin
            // Lst always ends the operation, even when it arrives early.
            rBusy <= 1'b0;
            if (rIdx != LAST_IDX) rErr <= 1'b1;
        end else if (stepFlag) begin
            if (rIdx == LAST_IDX) begin
                rErr <= 1'b1;
            end else begin
                rKey  <= nextKey;
                rRcon <= xtime(rRcon);
                rIdx  <= rIdx + 1'b1;
            end
        end
    end

`ifdef AES_KEY_LAST_CACHE_EN
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            oLastKey    <= '0;
            oLastKeyVld <= 1'b0;
        end else if (!rBusy) begin
            if (iStAes) oLastKeyVld <= 1'b0;
        end else if (!multiFlag && iLstRoundFlag && rIdx == LAST_IDX) begin
            oLastKey    <= rKey;
            oLastKeyVld <= 1'b1;
        end
    end
`endif

    assign oRoundKey = rKey;
    assign oRoundIdx = rIdx;
    assign oKeyBusy  = rBusy;
    assign oKeyErr   = rErr;
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a GF(2^8)-derived key schedule model.
module tb_aes_key_expand;
    logic         iClk = 1'b0;
    logic         iRsn = 1'b0;
    logic         iStAes = 1'b0;
    logic [127:0] iKey = '0;
    logic         iInitRoundFlag = 1'b0, iFstRoundFlag = 1'b0, iMidRoundFlag = 1'b0, iLstRoundFlag = 1'b0;
    logic [127:0] oRoundKey;
    logic [3:0]   oRoundIdx;
    logic         oKeyBusy, oKeyErr;
`ifdef AES_KEY_LAST_CACHE_EN
    logic [127:0] oLastKey;
    logic         oLastKeyVld;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0]   sbox [0:255];
    logic [127:0] mk [0:10];

    always #5 iClk = ~iClk;

    aes_key_expand dut (
        .iClk(iClk), .iRsn(iRsn), .iStAes(iStAes), .iKey(iKey),
        .iInitRoundFlag(iInitRoundFlag), .iFstRoundFlag(iFstRoundFlag),
        .iMidRoundFlag(iMidRoundFlag), .iLstRoundFlag(iLstRoundFlag),
`ifdef AES_KEY_LAST_CACHE_EN
        .oLastKey(oLastKey), .oLastKeyVld(oLastKeyVld),
`endif
        .oRoundKey(oRoundKey), .oRoundIdx(oRoundIdx), .oKeyBusy(oKeyBusy), .oKeyErr(oKeyErr)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic buildSbox;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-indexed key expansion w[0..43] in the textbook form.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic startOp(input logic [127:0] key);
        iKey = key;
        iStAes = 1'b1;
        tick();
        iStAes = 1'b0;
        expand(key);
    endtask

    // Full controller sequence; optionally fires a second start mid-operation.
    task automatic runOp(input logic [127:0] key, input bit intrude);
        startOp(key);
        iInitRoundFlag = 1'b1;
        chk("init_key", oRoundKey, mk[0]);
        chk("init_idx", 128'(oRoundIdx), 128'd0);
        chk("init_busy", 128'(oKeyBusy), 128'd1);
        chk("start_err_clr", 128'(oKeyErr), 128'd0);
        tick();
        iInitRoundFlag = 1'b0;
        iFstRoundFlag = 1'b1;
        chk("fst_key", oRoundKey, mk[1]);
        tick();
        iFstRoundFlag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iMidRoundFlag = 1'b1;
            if (intrude && i == 3) begin
                iStAes = 1'b1;
                iKey = ~key;
            end
            chk("mid_key", oRoundKey, mk[2+i]);
            chk("mid_idx", 128'(oRoundIdx), 128'(2+i));
            tick();
            iStAes = 1'b0;
        end
        iMidRoundFlag = 1'b0;
        iLstRoundFlag = 1'b1;
        chk("lst_key", oRoundKey, mk[10]);
        chk("lst_idx", 128'(oRoundIdx), 128'd10);
        tick();
        iLstRoundFlag = 1'b0;
        chk("done_busy", 128'(oKeyBusy), 128'd0);
        chk("done_key", oRoundKey, mk[10]);
        chk("done_idx", 128'(oRoundIdx), 128'd10);
        chk("done_err", 128'(oKeyErr), 128'd0);
    endtask

    function automatic logic [127:0] randKey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        buildSbox();
        tick();
        tick();
        chk("rst_key", oRoundKey, 128'd0);
        chk("rst_idx", 128'(oRoundIdx), 128'd0);
        chk("rst_busy", 128'(oKeyBusy), 128'd0);
        chk("rst_err", 128'(oKeyErr), 128'd0);
        iRsn = 1'b1;
        tick();

        // FIPS-197 example key, with fixed known-answer checks on top of the model.
        runOp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        chk("fips_key1", mk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_key10", oRoundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_LAST_CACHE_EN
        chk("cache_key", oLastKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("cache_vld", 128'(oLastKeyVld), 128'd1);
        startOp(128'h0);
        chk("cache_vld_clr", 128'(oLastKeyVld), 128'd0);
        chk("cache_key_hold", oLastKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        iRsn = 1'b0;
        tick();
        iRsn = 1'b1;
`endif

        // All-zero key.
        runOp(128'h0, 1'b0);
        chk("zero_key1", mk[1], 128'h62636363626363636263636362636363);

        // Random keys; one with a start fired mid-operation that must be ignored.
        runOp(randKey(), 1'b0);
        runOp(randKey(), 1'b1);
        runOp(randKey(), 1'b0);

        // Lone Fst flag while idle.
        iFstRoundFlag = 1'b1;
        tick();
        iFstRoundFlag = 1'b0;
        chk("idle_flag_err", 128'(oKeyErr), 128'd1);
        chk("idle_flag_key", oRoundKey, mk[10]);
        chk("idle_flag_busy", 128'(oKeyBusy), 128'd0);

        // Extra Mid at idx 10: error, key saturates; next start clears the error.
        startOp(randKey());
        chk("err_clr_on_start", 128'(oKeyErr), 128'd0);
        for (int i = 0; i < 11; i++) begin
            iInitRoundFlag = (i == 0);
            iFstRoundFlag  = (i == 1);
            iMidRoundFlag  = (i >= 2);
            tick();
        end
        iMidRoundFlag = 1'b0;
        chk("sat_err", 128'(oKeyErr), 128'd1);
        chk("sat_key", oRoundKey, mk[10]);
        chk("sat_idx", 128'(oRoundIdx), 128'd10);
        chk("sat_busy", 128'(oKeyBusy), 128'd1);
        iLstRoundFlag = 1'b1;
        tick();
        iLstRoundFlag = 1'b0;
        chk("sat_lst_busy", 128'(oKeyBusy), 128'd0);

        // Reset mid-operation, then a fresh start.
        startOp(randKey());
        iInitRoundFlag = 1'b1;
        tick();
        iInitRoundFlag = 1'b0;
        iFstRoundFlag = 1'b1;
        tick();
        iFstRoundFlag = 1'b0;
        iMidRoundFlag = 1'b1;
        tick();
        iRsn = 1'b0;
        tick();
        iMidRoundFlag = 1'b0;
        iRsn = 1'b1;
        chk("midrst_key", oRoundKey, 128'd0);
        chk("midrst_idx", 128'(oRoundIdx), 128'd0);
        chk("midrst_busy", 128'(oKeyBusy), 128'd0);
        chk("midrst_err", 128'(oKeyErr), 128'd0);
        runOp(randKey(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
